md5_msg_padder: RTL and testbench
=================================

// Module: md5_msg_padder
// PURPOSE
//  Message front-end for the MD5 core: packs a byte stream into 512-bit blocks and applies MD5
//  padding (0x80, zeros, 64-bit little-endian bit length). Emits blocks in the core's word
//  layout (word i at bits [32i+31:32i]). Sits upstream of md5update; its blk handshake drives
//  that core's enable.
// PARAMETERS
//  LEN_W  64  width of the bit-length counter; wraps mod 2^LEN_W; zero-extended to 64 in the block
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input byte offered
//  in_ready   out  1    padder accepts byte this cycle
//  in_data    in   8    message byte
//  in_keep    in   1    1 = in_data is message data; 0 is legal only with in_last (empty tail)
//  in_last    in   1    final beat of the message
//  blk_valid  out  1    blk_data holds a complete block
//  blk_ready  in   1    consumer takes block
//  blk_data   out  512  block; message byte k of block at bits [8k+7:8k]
//  blk_last   out  1    block is the final padded block of the message
// BEHAVIOUR
//  Reset (async): state=FILL, idx=0, len=0, buffer=0, pend=NONE; in_ready=0 while rst_n low,
//    then 1 from the first clock after release; blk_valid=0, blk_last=0, blk_data=0.
//  States: FILL, PAD, EMIT. pend in {NONE, NEED80, NEEDLEN}.
//  FILL: in_ready=1, blk_valid=0. Beat accepted on in_valid&&in_ready:
//   - keep=1: buf byte[idx]=in_data, idx++, len+=8.
//   - 64th byte of block (idx was 63): ->EMIT, blk_last=0; pend=NEED80 if in_last else NONE.
//   - else if in_last: ->PAD. keep=0 with in_last: ->PAD, no byte, len unchanged.
//   - keep=0 without in_last: beat dropped, no state change.
//  PAD (1 cycle, in_ready=0):
//   - if pend!=NEEDLEN: byte[idx]=0x80, bytes idx+1..63=0, else all bytes=0.
//   - if 0x80 landed at idx<=55, or pend==NEEDLEN: bits[511:448]=len, blk_last=1, pend=NONE.
//   - else (idx 56..63): blk_last=0, pend=NEEDLEN. Always ->EMIT.
//  EMIT: blk_valid=1, in_ready=0; blk_data/blk_last held stable until blk_ready.
//   On handshake: idx=0, buffer cleared; if blk_last: len=0, ->FILL;
//   else if pend!=NONE: ->PAD; else ->FILL.
//  Latency: full 64-byte block: blk_valid the cycle after last byte accept. Final block:
//   +2 cycles after in_last accept (PAD, then EMIT). No throughput overlap: one block in flight.
//  Length counts bits only of keep=1 bytes; wraps silently at 2^LEN_W.
//  in_last with 64th byte: NEED80 path puts 0x80 at byte 0 of next block.
//  Reset mid-message discards partial block, length, and any pending padding.
//  blk_valid never drops without blk_ready; in_valid ignored outside FILL.
// TESTING
//  "abc" (61,62,63, last on 63) -> one block: blk_data[31:0]=32'h80636261,
//   [511:448]=64'd24, others 0, blk_last=1.
//  Empty msg (keep=0,last=1) -> blk_data[7:0]=8'h80, rest 0, blk_last=1.
//  55 bytes 0xAA -> one block: byte55=0x80, [511:448]=440, blk_last=1.
//  56 bytes -> block1: byte56=0x80, bytes57-63=0, blk_last=0; block2: zeros, [511:448]=448, last=1.
//  64 bytes 0..63 -> block1 raw data, blk_last=0 (blk_valid 1 cycle after accept);
//   block2: byte0=0x80, [511:448]=512, blk_last=1.
//  blk_ready low 5 cycles in EMIT -> blk_data stable, in_ready=0; rst_n pulse mid-block
//   -> blk_valid=0 immediately; next "abc" yields the reference "abc" block.

Source files
------------

// File: rtl/md5_msg_padder_if.sv
// Byte-stream in / 512-bit block out bundle for the MD5 message padder.
// slave: padder side; master: producer of bytes and consumer of blocks.
interface md5_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport slave (
    input  in_valid, in_data, in_keep, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

  modport master (
    output in_valid, in_data, in_keep, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/md5_msg_padder.sv
// MD5 message front-end: packs bytes into 512-bit blocks, adds 0x80/zeros/LE bit length.
// Ports: clk, rst_n (async low), io (slave): byte stream in, block stream out.
module md5_msg_padder #(
  parameter int LEN_W = 64
) (
  input logic            clk,
  input logic            rst_n,
  md5_msg_padder_if.slave io
);
  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;
  typedef enum logic [1:0] {NONE, NEED80, NEEDLEN} pend_t;

  state_t           state_q, state_d;
  pend_t            pend_q;
  logic [5:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic [511:0]     blk_q;
  logic             last_q;
  logic             rdy_q;
  logic [63:0]      len64;
  logic             acc, full, hs;

  assign acc  = io.in_valid && io.in_ready;
  assign full = acc && io.in_keep && (idx_q == 6'd63);
  assign hs   = io.blk_valid && io.blk_ready;
  assign len64 = 64'(len_q);

  assign io.in_ready  = rdy_q && (state_q == FILL);
  assign io.blk_valid = (state_q == EMIT);
  assign io.blk_data  = blk_q;
  assign io.blk_last  = last_q;

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (full)
          state_d = EMIT;
        else if (acc && io.in_last)
          state_d = PAD;
      end
      PAD: state_d = EMIT;
      EMIT: begin
        if (hs) begin
          if (last_q)             state_d = FILL;
          else if (pend_q != NONE) state_d = PAD;
          else                    state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= NONE;
      idx_q  <= '0;
      len_q  <= '0;
      blk_q  <= '0;
      last_q <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (acc && io.in_keep) begin
            blk_q[{idx_q, 3'b000} +: 8] <= io.in_data;
            idx_q <= idx_q + 6'd1;
            len_q <= len_q + LEN_W'(8);
          end
          if (full) begin
            last_q <= 1'b0;
            pend_q <= io.in_last ? NEED80 : NONE;
          end
        end
        PAD: begin
          // Bytes below idx keep message data; 0x80 at idx; rest zero.
          for (int k = 0; k < 64; k++) begin
            if (pend_q == NEEDLEN || 6'(k) > idx_q)
              blk_q[8*k +: 8] <= 8'h00;
            else if (6'(k) == idx_q)
              blk_q[8*k +: 8] <= 8'h80;
          end
          // Length only fits when the marker left bytes 56..63 free.
          if (pend_q == NEEDLEN || idx_q <= 6'd55) begin
            blk_q[511:448] <= len64;
            last_q <= 1'b1;
            pend_q <= NONE;
          end else begin
            last_q <= 1'b0;
            pend_q <= NEEDLEN;
          end
        end
        EMIT: begin
          if (hs) begin
            idx_q  <= '0;
            blk_q  <= '0;
            last_q <= 1'b0;
            if (last_q) len_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_msg_padder.sv
// Self-checking bench for md5_msg_padder against a queue-based MD5 padding model.
// Drives random messages, fixed vectors, stalls, resets and back-to-back traffic.
module tb_md5_msg_padder;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_msg_padder_if io();

  md5_msg_padder #(.LEN_W(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  int tests = 0;
  int fails = 0;
  bit hold  = 1'b1;

  logic [511:0] got_d[$];
  bit           got_l[$];
  logic [511:0] exp_d[$];
  bit           exp_l[$];

  always @(posedge clk)
    if (rst_n && io.blk_valid && io.blk_ready) begin
      got_d.push_back(io.blk_data);
      got_l.push_back(io.blk_last);
    end

  initial begin
    io.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      io.blk_ready = !hold && ($urandom_range(0, 3) != 0);
    end
  end

  // Plain MD5 padding: msg, 0x80, zeros to 56 mod 64, 64-bit LE bit count.
  task automatic model(input bq_t m);
    bq_t q;
    logic [63:0] bl;
    logic [511:0] b;
    int nb;
    exp_d.delete();
    exp_l.delete();
    q = m;
    bl = 64'(m.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 0; i < 8; i++) q.push_back(bl[8*i +: 8]);
    nb = q.size() / 64;
    for (int j = 0; j < nb; j++) begin
      b = '0;
      for (int k = 0; k < 64; k++) b[8*k +: 8] = q[64*j + k];
      exp_d.push_back(b);
      exp_l.push_back(j == nb - 1);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input bit k, input bit l);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_keep  = k;
    io.in_last  = l;
    while (!io.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!io.in_ready) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", io.in_ready, n);
    end else begin
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
  endtask

  task automatic send_msg(input bq_t m, input bit empty_tail, input bit noise);
    for (int i = 0; i < m.size(); i++) begin
      if (noise && $urandom_range(0, 3) == 0)
        drive_beat(8'($urandom), 1'b0, 1'b0);
      drive_beat(m[i], 1'b1, !empty_tail && (i == m.size() - 1));
    end
    if (empty_tail || m.size() == 0)
      drive_beat(8'($urandom), 1'b0, 1'b1);
  endtask

  task automatic wait_blocks(input int base, input int n);
    int c = 0;
    while (got_d.size() < base + n && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (got_d.size() < base + n) begin
      tests++;
      fails++;
      $display("FAIL block_timeout: got %0d blocks, required %0d", got_d.size() - base, n);
    end
  endtask

  function automatic logic [511:0] abc_blk();
    logic [511:0] e = '0;
    e[31:0] = 32'h80636261;
    e[511:448] = 64'd24;
    return e;
  endfunction

  task automatic test_reset();
    io.in_valid = 1'b0;
    io.in_data  = 8'h00;
    io.in_keep  = 1'b0;
    io.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_ready: got %0b, required 0", io.in_ready);
    end
    tests++;
    if (io.blk_valid !== 1'b0 || io.blk_last !== 1'b0) begin
      fails++;
      $display("FAIL rst_blk_flags: valid=%0b last=%0b, required 0 0", io.blk_valid, io.blk_last);
    end
    tests++;
    if (io.blk_data !== 512'd0) begin
      fails++;
      $display("FAIL rst_blk_data: got %h, required 0", io.blk_data);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_release_early: in_ready=%0b, required 0", io.in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release: in_ready=%0b, required 1", io.in_ready);
    end
  endtask

  task automatic test_vectors();
    bq_t m;
    int base;
    logic [511:0] e;
    hold = 1'b0;
    for (int v = 0; v < 5; v++) begin
      m.delete();
      case (v)
        0: begin m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63); end
        1: ;
        2: for (int i = 0; i < 55; i++) m.push_back(8'hAA);
        3: for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        default: for (int i = 0; i < 64; i++) m.push_back(8'(i));
      endcase
      model(m);
      base = got_d.size();
      send_msg(m, 1'b0, 1'b0);
      wait_blocks(base, exp_d.size());
      for (int i = 0; i < exp_d.size() && base + i < got_d.size(); i++) begin
        tests++;
        if (got_d[base+i] !== exp_d[i] || got_l[base+i] !== exp_l[i]) begin
          fails++;
          $display("FAIL vec%0d_blk%0d: got last=%0b %h, required last=%0b %h",
                   v, i, got_l[base+i], got_d[base+i], exp_l[i], exp_d[i]);
        end
      end
      e = '0;
      tests++;
      case (v)
        0: begin
          if (got_d[base] !== abc_blk() || got_l[base] !== 1'b1) begin
            fails++;
            $display("FAIL abc_const: got %h, required %h", got_d[base], abc_blk());
          end
        end
        1: begin
          e[7:0] = 8'h80;
          if (got_d[base] !== e || got_l[base] !== 1'b1) begin
            fails++;
            $display("FAIL empty_const: got %h, required %h", got_d[base], e);
          end
        end
        2: begin
          for (int i = 0; i < 55; i++) e[8*i +: 8] = 8'hAA;
          e[447:440] = 8'h80;
          e[511:448] = 64'd440;
          if (got_d[base] !== e || got_l[base] !== 1'b1) begin
            fails++;
            $display("FAIL len55_const: got %h, required %h", got_d[base], e);
          end
        end
        3: begin
          if (got_d[base][511:448] !== 64'h80 || got_l[base] !== 1'b0 ||
              got_d[base+1][511:448] !== 64'd448 || got_d[base+1][447:0] !== 448'd0) begin
            fails++;
            $display("FAIL len56_const: got tail0=%h tail1=%h, required 80 and 448",
                     got_d[base][511:448], got_d[base+1][511:448]);
          end
        end
        default: begin
          if (got_d[base+1][7:0] !== 8'h80 || got_d[base+1][511:448] !== 64'd512 ||
              got_l[base] !== 1'b0 || got_l[base+1] !== 1'b1) begin
            fails++;
            $display("FAIL len64_const: got byte0=%h len=%0d, required 80 and 512",
                     got_d[base+1][7:0], got_d[base+1][511:448]);
          end
        end
      endcase
    end
  endtask

  task automatic test_latency();
    int base;
    hold = 1'b1;
    for (int i = 0; i < 63; i++) drive_beat(8'(i), 1'b1, 1'b0);
    drive_beat(8'h3F, 1'b1, 1'b0);
    tests++;
    if (io.blk_valid !== 1'b1 || io.blk_last !== 1'b0) begin
      fails++;
      $display("FAIL full_latency: valid=%0b last=%0b, required 1 0", io.blk_valid, io.blk_last);
    end
    base = got_d.size();
    hold = 1'b0;
    wait_blocks(base, 1);
    hold = 1'b1;
    drive_beat(8'h61, 1'b1, 1'b0);
    drive_beat(8'h62, 1'b1, 1'b0);
    drive_beat(8'h63, 1'b1, 1'b1);
    tests++;
    if (io.blk_valid !== 1'b0 || io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL pad_cycle: valid=%0b in_ready=%0b, required 0 0", io.blk_valid, io.in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (io.blk_valid !== 1'b1 || io.blk_last !== 1'b1) begin
      fails++;
      $display("FAIL final_latency: valid=%0b last=%0b, required 1 1", io.blk_valid, io.blk_last);
    end
    tests++;
    if (io.blk_data[31:0] !== 32'h80636261 || io.blk_data[511:448] !== 64'd536) begin
      fails++;
      $display("FAIL two_block_len: got w0=%h len=%0d, required 80636261 536",
               io.blk_data[31:0], io.blk_data[511:448]);
    end
    base = got_d.size();
    hold = 1'b0;
    wait_blocks(base, 1);
  endtask

  task automatic test_stall();
    int base;
    int c = 0;
    logic [511:0] snap;
    hold = 1'b1;
    base = got_d.size();
    drive_beat(8'h61, 1'b1, 1'b0);
    drive_beat(8'h62, 1'b1, 1'b0);
    drive_beat(8'h63, 1'b1, 1'b1);
    while (!io.blk_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    snap = io.blk_data;
    io.in_valid = 1'b1;
    io.in_data  = 8'hFF;
    io.in_keep  = 1'b1;
    io.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (io.blk_valid !== 1'b1 || io.in_ready !== 1'b0 || io.blk_data !== snap) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%0b in_ready=%0b data=%h, required 1 0 %h",
                 i, io.blk_valid, io.in_ready, io.blk_data, snap);
      end
    end
    io.in_valid = 1'b0;
    hold = 1'b0;
    wait_blocks(base, 1);
    tests++;
    if (got_d[base] !== abc_blk() || got_l[base] !== 1'b1) begin
      fails++;
      $display("FAIL stall_block: got %h, required %h", got_d[base], abc_blk());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    hold = 1'b1;
    for (int i = 0; i < 64; i++) drive_beat(8'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    tests++;
    if (io.blk_valid !== 1'b0 || io.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_emit: valid=%0b in_ready=%0b, required 0 0", io.blk_valid, io.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) drive_beat(8'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = got_d.size();
    hold = 1'b0;
    drive_beat(8'h61, 1'b1, 1'b0);
    drive_beat(8'h62, 1'b1, 1'b0);
    drive_beat(8'h63, 1'b1, 1'b1);
    wait_blocks(base, 1);
    tests++;
    if (got_d[base] !== abc_blk() || got_l[base] !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_abc: got %h, required %h", got_d[base], abc_blk());
    end
  endtask

  task automatic test_random();
    bq_t m;
    int base;
    hold = 1'b0;
    for (int t = 0; t < 10; t++) begin
      m.delete();
      for (int i = 0; i < $urandom_range(0, 140); i++) m.push_back(8'($urandom));
      model(m);
      base = got_d.size();
      send_msg(m, 1'($urandom), 1'b1);
      wait_blocks(base, exp_d.size());
      tests++;
      if (got_d.size() - base != exp_d.size()) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d blocks, required %0d",
                 t, got_d.size() - base, exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && base + i < got_d.size(); i++) begin
        tests++;
        if (got_d[base+i] !== exp_d[i] || got_l[base+i] !== exp_l[i]) begin
          fails++;
          $display("FAIL rand%0d_blk%0d: got last=%0b %h, required last=%0b %h",
                   t, i, got_l[base+i], got_d[base+i], exp_l[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t m1, m2;
    logic [511:0] e_d[$];
    bit e_l[$];
    int base;
    hold = 1'b0;
    for (int i = 0; i < 60; i++) m1.push_back(8'($urandom));
    for (int i = 0; i < 7; i++) m2.push_back(8'($urandom));
    model(m1);
    e_d = exp_d;
    e_l = exp_l;
    model(m2);
    foreach (exp_d[i]) begin
      e_d.push_back(exp_d[i]);
      e_l.push_back(exp_l[i]);
    end
    base = got_d.size();
    send_msg(m1, 1'b0, 1'b0);
    send_msg(m2, 1'b0, 1'b0);
    wait_blocks(base, e_d.size());
    for (int i = 0; i < e_d.size() && base + i < got_d.size(); i++) begin
      tests++;
      if (got_d[base+i] !== e_d[i] || got_l[base+i] !== e_l[i]) begin
        fails++;
        $display("FAIL b2b_blk%0d: got last=%0b %h, required last=%0b %h",
                 i, got_l[base+i], got_d[base+i], e_l[i], e_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
